// File: rtl/sat_filter_pkg.sv
// sat_filter_pkg: shared limit/result types and default-limit helpers for the
// saturation filter family. Values are carried at MAX_W bits, sign- or
// zero-extended from the sample width, so one set of types serves every width.
package sat_filter_pkg;

  localparam int MAX_W = 32;

  typedef struct packed {
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] lo;
  } limit_pair_t;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             ovf_hi;
    logic             ovf_lo;
  } clamp_res_t;

  // Largest positive two's-complement value of a w-bit sample.
  function automatic logic [MAX_W-1:0] hi_default(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] lo_default();
    return '0;
  endfunction

  // Widen a w-bit value (given zero-extended) to MAX_W, sign-extending if sgn.
  function automatic logic [MAX_W-1:0] extend_val(input logic [MAX_W-1:0] v,
                                                  input int w, input bit sgn);
    logic [MAX_W-1:0] r;
    r = v;
    for (int i = 0; i < MAX_W; i++)
      if (i >= w) r[i] = sgn ? v[w-1] : 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sat_filter_mc_if.sv
// sat_filter_mc_if: configuration, sample stream and statistics signals of the
// multi-channel saturation filter. Statistics signals exist only when
// SAT_FILTER_STATS_EN is defined.
interface sat_filter_mc_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DATA_W-1:0] cfg_hi;
  logic [DATA_W-1:0] cfg_lo;
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf_hi;
  logic              out_ovf_lo;
`ifdef SAT_FILTER_STATS_EN
  logic [CH_W-1:0]   stat_ch;
  logic [CNT_W-1:0]  stat_cnt;
  logic              stat_clr;
`endif

  modport master (
    output cfg_we, cfg_ch, cfg_hi, cfg_lo,
    output in_valid, in_ch, in_data,
    input  in_ready,
    input  out_valid, out_ch, out_data, out_ovf_hi, out_ovf_lo,
    output out_ready
`ifdef SAT_FILTER_STATS_EN
    , output stat_ch, stat_clr
    , input  stat_cnt
`endif
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_hi, cfg_lo,
    input  in_valid, in_ch, in_data,
    output in_ready,
    output out_valid, out_ch, out_data, out_ovf_hi, out_ovf_lo,
    input  out_ready
`ifdef SAT_FILTER_STATS_EN
    , input  stat_ch, stat_clr
    , output stat_cnt
`endif
  );

endinterface

// File: rtl/sat_clamp_lane.sv
// sat_clamp_lane: combinational compare-and-clamp of one sample against a
// limit pair. Upper limit has priority, so lo > hi always yields a limit.
module sat_clamp_lane
  import sat_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] data,
  input  limit_pair_t       lim,
  output clamp_res_t        res
);

  logic [MAX_W-1:0] data_x;
  logic             above_hi;
  logic             below_lo;

  assign data_x = extend_val(MAX_W'(data), DATA_W, SIGNED);

  // Compare the widened sample against both limits in the selected arithmetic.
  always_comb begin
    if (SIGNED) begin
      above_hi = $signed(data_x) > $signed(lim.hi);
      below_lo = $signed(data_x) < $signed(lim.lo);
    end else begin
      above_hi = data_x > lim.hi;
      below_lo = data_x < lim.lo;
    end
  end

  // Select the clamped value; the upper-limit check wins over the lower one.
  always_comb begin
    res      = '0;
    res.data = data_x;
    if (above_hi) begin
      res.data   = lim.hi;
      res.ovf_hi = 1'b1;
    end else if (below_lo) begin
      res.data   = lim.lo;
      res.ovf_lo = 1'b1;
    end
  end

endmodule

// File: rtl/sat_filter_mc.sv
// sat_filter_mc: time-multiplexed per-channel saturation filter, two-stage
// valid/ready pipeline with full backpressure. Define SAT_FILTER_STATS_EN to
// add per-channel saturating clamp-event counters.
module sat_filter_mc
  import sat_filter_pkg::*;
#(
  parameter int              DATA_W = 8,
  parameter int              N_CH   = 4,
  parameter bit              SIGNED = 1'b0,
  parameter logic [DATA_W-1:0] HI_DEF = DATA_W'(hi_default(DATA_W)),
  parameter logic [DATA_W-1:0] LO_DEF = DATA_W'(lo_default()),
  parameter int              CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  sat_filter_mc_if.slave bus
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DEPTH = 1 << CH_W;
  localparam limit_pair_t LIM_RST = '{hi: extend_val(MAX_W'(HI_DEF), DATA_W, SIGNED),
                                      lo: extend_val(MAX_W'(LO_DEF), DATA_W, SIGNED)};

  limit_pair_t       lim_q [DEPTH];
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [CH_W-1:0]   s1_ch;
  limit_pair_t       s1_lim;
  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic [CH_W-1:0]   s2_ch;
  logic              s2_hi;
  logic              s2_lo;
  logic              s1_adv;
  logic              s2_adv;
  clamp_res_t        clamp_res;
  logic              unused_clamp;

  // A stage may load when it is empty or its contents leave this cycle.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  // Per-channel limit register file; a write lands after a same-cycle read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) lim_q[i] <= LIM_RST;
    end else if (bus.cfg_we) begin
      lim_q[bus.cfg_ch] <= '{hi: extend_val(MAX_W'(bus.cfg_hi), DATA_W, SIGNED),
                             lo: extend_val(MAX_W'(bus.cfg_lo), DATA_W, SIGNED)};
    end
  end

  // Stage 1 captures the sample together with its channel's current limits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_ch    <= '0;
      s1_lim   <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data <= bus.in_data;
        s1_ch   <= bus.in_ch;
        s1_lim  <= lim_q[bus.in_ch];
      end
    end
  end

  sat_clamp_lane #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_lane (
    .data (s1_data),
    .lim  (s1_lim),
    .res  (clamp_res)
  );

  assign unused_clamp = ^clamp_res.data;

  // Stage 2 registers the clamp result and holds it while the output stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ch    <= '0;
      s2_hi    <= 1'b0;
      s2_lo    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= clamp_res.data[DATA_W-1:0];
        s2_ch   <= s1_ch;
        s2_hi   <= clamp_res.ovf_hi;
        s2_lo   <= clamp_res.ovf_lo;
      end
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_data   = s2_data;
  assign bus.out_ch     = s2_ch;
  assign bus.out_ovf_hi = s2_hi;
  assign bus.out_ovf_lo = s2_lo;

`ifdef SAT_FILTER_STATS_EN
  logic [CNT_W-1:0] cnt_q [DEPTH];

  // Count clamped samples as they leave; clear beats increment, no wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else if (bus.stat_clr) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else if (s2_valid && bus.out_ready && (s2_hi || s2_lo)) begin
      if (cnt_q[s2_ch] != {CNT_W{1'b1}}) cnt_q[s2_ch] <= cnt_q[s2_ch] + CNT_W'(1);
    end
  end

  assign bus.stat_cnt = cnt_q[bus.stat_ch];
`endif

endmodule

// File: tb/tb_sat_filter_mc.sv
// tb_sat_filter_mc: directed self-checking bench for sat_filter_mc. An unsigned
// instance carries the main scenarios; a SIGNED=1 instance checks signed clamps.
module tb_sat_filter_mc;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   acc_cnt;
  int   mq_ch[$];
  int   mq_data[$];
  int   mq_hi[$];
  int   mq_lo[$];

  sat_filter_mc_if #(.DATA_W(8), .N_CH(4), .CNT_W(2)) bus ();
  sat_filter_mc_if #(.DATA_W(8), .N_CH(4), .CNT_W(16)) bus_s ();

  sat_filter_mc #(.DATA_W(8), .N_CH(4), .SIGNED(1'b0), .CNT_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sat_filter_mc #(.DATA_W(8), .N_CH(4), .SIGNED(1'b1), .CNT_W(16)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output transfer and every input accept mid-cycle.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      mq_ch.push_back(int'(bus.out_ch));
      mq_data.push_back(int'(bus.out_data));
      mq_hi.push_back(int'(bus.out_ovf_hi));
      mq_lo.push_back(int'(bus.out_ovf_lo));
    end
    if (bus.in_valid && bus.in_ready) acc_cnt++;
  end

  task automatic clear_mon();
    mq_ch.delete();
    mq_data.delete();
    mq_hi.delete();
    mq_lo.delete();
    acc_cnt = 0;
  endtask

  task automatic idle_inputs();
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_hi = '0; bus.cfg_lo = '0;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus_s.cfg_we = 1'b0; bus_s.cfg_ch = '0; bus_s.cfg_hi = '0; bus_s.cfg_lo = '0;
    bus_s.in_valid = 1'b0; bus_s.in_ch = '0; bus_s.in_data = '0; bus_s.out_ready = 1'b1;
`ifdef SAT_FILTER_STATS_EN
    bus.stat_ch = '0; bus.stat_clr = 1'b0;
    bus_s.stat_ch = '0; bus_s.stat_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  // Offer one sample on the unsigned instance and hold it until accepted.
  task automatic send(input int ch, input int data);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'(ch);
    bus.in_data  = 8'(data);
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("[TB] FAIL send_timeout: in_ready stuck at %0d, required 1", bus.in_ready);
        break;
      end
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int hi, input int lo);
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'(ch); bus.cfg_hi = 8'(hi); bus.cfg_lo = 8'(lo);
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (mq_data.size() < n && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    checks++;
    if (mq_data.size() < n) begin
      failures++;
      $display("[TB] FAIL wait_out: got %0d outputs, required %0d", mq_data.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.out_ovf_hi, bus.out_ovf_lo} !== 13'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got v=%0b d=%0d ch=%0d hi=%0b lo=%0b, required all 0",
               bus.out_valid, bus.out_data, bus.out_ch, bus.out_ovf_hi, bus.out_ovf_lo);
    end
    checks++;
    if (bus_s.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid_s: got %0b, required 0", bus_s.out_valid);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
    end
    clear_mon();
  endtask

  task automatic test_default_limits();
    int exp_d[3] = '{127, 50, 0};
    int exp_h[3] = '{1, 0, 0};
    clear_mon();
    send(0, 200);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_early: out_valid got %0b one cycle after accept, required 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd127 || bus.out_ovf_hi !== 1'b1) begin
      failures++;
      $display("[TB] FAIL latency_two: got v=%0b d=%0d hi=%0b, required v=1 d=127 hi=1",
               bus.out_valid, bus.out_data, bus.out_ovf_hi);
    end
    send(0, 50);
    send(0, 0);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mq_ch[i] !== 0 || mq_data[i] !== exp_d[i] || mq_hi[i] !== exp_h[i] || mq_lo[i] !== 0) begin
        failures++;
        $display("[TB] FAIL default_lim[%0d]: got ch=%0d d=%0d hi=%0d lo=%0d, required ch=0 d=%0d hi=%0d lo=0",
                 i, mq_ch[i], mq_data[i], mq_hi[i], mq_lo[i], exp_d[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_per_channel();
    int exp_c[3] = '{2, 1, 2};
    int exp_d[3] = '{20, 10, 100};
    int exp_h[3] = '{0, 0, 1};
    int exp_l[3] = '{1, 0, 0};
    clear_mon();
    cfg_write(2, 100, 20);
    send(2, 10);
    send(1, 10);
    send(2, 150);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mq_ch[i] !== exp_c[i] || mq_data[i] !== exp_d[i] || mq_hi[i] !== exp_h[i] || mq_lo[i] !== exp_l[i]) begin
        failures++;
        $display("[TB] FAIL per_channel[%0d]: got ch=%0d d=%0d hi=%0d lo=%0d, required ch=%0d d=%0d hi=%0d lo=%0d",
                 i, mq_ch[i], mq_data[i], mq_hi[i], mq_lo[i], exp_c[i], exp_d[i], exp_h[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    int in_c[6]  = '{1, 1, 0, 0, 2, 2};
    int in_d[6]  = '{30, 5, 127, 128, 20, 100};
    int exp_d[6] = '{10, 50, 127, 127, 20, 100};
    int exp_h[6] = '{1, 0, 0, 1, 0, 0};
    int exp_l[6] = '{0, 1, 0, 0, 0, 0};
    clear_mon();
    cfg_write(1, 10, 50);
    for (int i = 0; i < 6; i++) send(in_c[i], in_d[i]);
    wait_out(6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mq_ch[i] !== in_c[i] || mq_data[i] !== exp_d[i] || mq_hi[i] !== exp_h[i] || mq_lo[i] !== exp_l[i]) begin
        failures++;
        $display("[TB] FAIL boundary[%0d]: got ch=%0d d=%0d hi=%0d lo=%0d, required ch=%0d d=%0d hi=%0d lo=%0d",
                 i, mq_ch[i], mq_data[i], mq_hi[i], mq_lo[i], in_c[i], exp_d[i], exp_h[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_signed();
    logic [7:0] in_d[3]  = '{8'h80, 8'h7F, 8'hFD};
    logic [7:0] exp_d[3] = '{8'hCE, 8'h32, 8'hFD};
    logic       exp_h[3] = '{1'b0, 1'b1, 1'b0};
    logic       exp_l[3] = '{1'b1, 1'b0, 1'b0};
    bus_s.cfg_we = 1'b1; bus_s.cfg_ch = 2'd0; bus_s.cfg_hi = 8'd50; bus_s.cfg_lo = 8'hCE;
    @(posedge clk);
    #1 bus_s.cfg_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus_s.in_valid = 1'b1; bus_s.in_ch = 2'd0; bus_s.in_data = in_d[i];
      end else begin
        bus_s.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        checks++;
        if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== exp_d[i-1] ||
            bus_s.out_ovf_hi !== exp_h[i-1] || bus_s.out_ovf_lo !== exp_l[i-1]) begin
          failures++;
          $display("[TB] FAIL signed[%0d]: got v=%0b d=%h hi=%0b lo=%0b, required v=1 d=%h hi=%0b lo=%0b",
                   i - 1, bus_s.out_valid, bus_s.out_data, bus_s.out_ovf_hi, bus_s.out_ovf_lo,
                   exp_d[i-1], exp_h[i-1], exp_l[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_d[8] = '{10, 40, 70, 100, 127, 127, 127, 127};
    int exp_h[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    do_reset();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i % 4, 10 + i * 30);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd10 || bus.out_ch !== 2'd0) begin
          failures++;
          $display("[TB] FAIL stall_hold_a: got v=%0b d=%0d ch=%0d, required v=1 d=10 ch=0",
                   bus.out_valid, bus.out_data, bus.out_ch);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 8'd10 || bus.out_ch !== 2'd0) begin
          failures++;
          $display("[TB] FAIL stall_hold_b: got in_ready=%0b d=%0d ch=%0d, required in_ready=0 d=10 ch=0",
                   bus.in_ready, bus.out_data, bus.out_ch);
        end
        checks++;
        if (acc_cnt !== 2) begin
          failures++;
          $display("[TB] FAIL stall_buffered: got %0d accepted, required 2", acc_cnt);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mq_ch[i] !== i % 4 || mq_data[i] !== exp_d[i] || mq_hi[i] !== exp_h[i] || mq_lo[i] !== 0) begin
        failures++;
        $display("[TB] FAIL backpressure[%0d]: got ch=%0d d=%0d hi=%0d lo=%0d, required ch=%0d d=%0d hi=%0d lo=0",
                 i, mq_ch[i], mq_data[i], mq_hi[i], mq_lo[i], i % 4, exp_d[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_cfg_collision();
    int exp_d[3] = '{64, 10, 64};
    int exp_h[3] = '{0, 1, 0};
    clear_mon();
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_hi = 8'd10; bus.cfg_lo = 8'd0;
    send(0, 64);
    bus.cfg_we = 1'b0;
    send(0, 64);
    cfg_write(0, 100, 0);
    send(0, 64);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mq_ch[i] !== 0 || mq_data[i] !== exp_d[i] || mq_hi[i] !== exp_h[i] || mq_lo[i] !== 0) begin
        failures++;
        $display("[TB] FAIL cfg_collision[%0d]: got ch=%0d d=%0d hi=%0d lo=%0d, required ch=0 d=%0d hi=%0d lo=0",
                 i, mq_ch[i], mq_data[i], mq_hi[i], mq_lo[i], exp_d[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_reset_flush();
    clear_mon();
    send(1, 5);
    send(1, 6);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_valid: got %0b during reset, required 0", bus.out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (mq_data.size() !== 0) begin
      failures++;
      $display("[TB] FAIL flush_emitted: got %0d outputs after reset, required 0", mq_data.size());
    end
  endtask

`ifdef SAT_FILTER_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) send(3, 200);
    wait_out(5);
    bus.stat_ch = 2'd3;
    #1;
    checks++;
    if (bus.stat_cnt !== 2'd3) begin
      failures++;
      $display("[TB] FAIL stat_saturate: got %0d, required 3", bus.stat_cnt);
    end
    bus.stat_ch = 2'd0;
    #1;
    checks++;
    if (bus.stat_cnt !== 2'd0) begin
      failures++;
      $display("[TB] FAIL stat_other_ch: got %0d, required 0", bus.stat_cnt);
    end
    bus.stat_ch = 2'd3;
    send(3, 200);
    @(posedge clk);
    #1 bus.stat_clr = 1'b1;
    @(posedge clk);
    #1 bus.stat_clr = 1'b0;
    checks++;
    if (bus.stat_cnt !== 2'd0 || mq_data.size() !== 6) begin
      failures++;
      $display("[TB] FAIL stat_clr_wins: got cnt=%0d outputs=%0d, required cnt=0 outputs=6",
               bus.stat_cnt, mq_data.size());
    end
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    checks   = 0;
    failures = 0;
    acc_cnt  = 0;
    test_reset();
    test_default_limits();
    test_per_channel();
    test_boundaries();
    test_signed();
    test_backpressure();
    test_cfg_collision();
    test_reset_flush();
`ifdef SAT_FILTER_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sat_filter_mc.md
# sat_filter_mc

Multi-channel, time-multiplexed saturation filter with per-channel programmable upper and lower clamp limits. It adds a valid/ready handshake with full backpressure and selectable signed or unsigned arithmetic. Optional per-channel saturation event counters are available. It sits in the sample path between an acquisition front end and downstream processing, and supersedes the single-threshold saturation filter for multi-channel streams.

## Interface
- DATA_W, 8, sample width in bits (2..32)
- N_CH, 4, channel count; power of two, 1..16; CH_W = max(1, $clog2(N_CH))
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned
- HI_DEF, 2**(DATA_W-1)-1, reset value of every channel's upper limit
- LO_DEF, 0, reset value of every channel's lower limit
- CNT_W, 16, event counter width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cfg_we  in  1  write limits for channel cfg_ch
- cfg_ch  in  CH_W  channel being configured
- cfg_hi  in  DATA_W  new upper limit
- cfg_lo  in  DATA_W  new lower limit
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_ch  in  CH_W  channel tag of the input sample
- in_data  in  DATA_W  input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_ch  out  CH_W  channel tag of the output sample
- out_data  out  DATA_W  filtered sample
- out_ovf_hi  out  1  sample was clamped to the upper limit
- out_ovf_lo  out  1  sample was clamped to the lower limit
- stat_ch  in  CH_W  counter read select (SAT_FILTER_STATS_EN only)
- stat_cnt  out  CNT_W  event count of stat_ch, combinational read (SAT_FILTER_STATS_EN only)
- stat_clr  in  1  clear all counters (SAT_FILTER_STATS_EN only)

## Operation
- A transfer occurs on a cycle with valid && ready at the respective interface.
- Per-channel limit register file: hi[N_CH] and lo[N_CH]. Written on cfg_we at the clock edge. Reset to HI_DEF/LO_DEF.
- Stage 1 (S1): on accept, registers data and channel, and reads hi[in_ch] and lo[in_ch].
- Stage 2 (S2): compares the S1 data against its captured limits and registers the result.
- Compare priority:
  - data > hi gives out_data = hi, out_ovf_hi = 1.
  - Else data < lo gives out_data = lo, out_ovf_lo = 1.
  - Else the sample passes unchanged.
  - The two flags are never both 1.
- lo > hi is a legal configuration and the priority still applies: every sample yields hi or lo, never a pass.
- Comparisons are signed when SIGNED = 1, unsigned otherwise. No width growth; outputs are always DATA_W.
- Each stage holds its contents when the successor is full and not advancing. No sample is dropped or duplicated.
- in_ready = !S1_valid || !S2_valid || out_ready. This is combinational from out_ready.
- out_ch, out_data and the flags are stable while out_valid && !out_ready.

## Timing
- Latency: 2 cycles from input accept to out_valid when unstalled. Throughput is one sample per cycle.
- Reset: out_valid = 0, out_data = 0, out_ch = 0, out_ovf_hi = 0, out_ovf_lo = 0, pipeline empty, limits = defaults, counters = 0.
- in_ready is 1 from the first cycle after reset deassertion.
- A config write and a sample accept on the same channel in the same cycle: the sample uses the old limits. The new limits apply from the next accepted sample.
- Limits are sampled at S1 entry. Later config writes do not affect samples already in flight.
- Reset asserted mid-stream flushes all in-flight samples immediately. Nothing is emitted afterwards.

## Configuration
- SAT_FILTER_STATS_EN defined:
  - An N_CH × CNT_W counter array increments for the sample's channel when a clamped sample transfers at the output.
  - Counters saturate at all-ones and do not wrap.
  - stat_clr zeroes every counter; clear wins over a same-cycle increment.
- SAT_FILTER_STATS_EN undefined: the stat_* ports and counters are absent and the rest of the behaviour is identical.

## Structure
- The shared package sat_filter_pkg holds:
  - the typedef for the limit pair (hi/lo struct)
  - the clamp-result struct (data, ovf_hi, ovf_lo)
  - the default-limit constant functions
- The sub-module sat_clamp_lane is the combinational signed/unsigned compare-and-clamp used in S2. It is reusable by the single-channel filter.

## Test plan
- Reset defaults, DATA_W = 8, unsigned, limits 127/0: inputs 200, 50, 0 on ch0 → outputs 127 (ovf_hi), 50, 0 two cycles later; flags correct.
- Per-channel config: ch2 set to hi = 100, lo = 20; inputs ch2:10, ch1:10, ch2:150 → 20 (ovf_lo), 10, 100 (ovf_hi).
- SIGNED = 1 with limits hi = 50, lo = -50: inputs -128, 127, -3 → -50 (ovf_lo), 50 (ovf_hi), -3.
- Backpressure: out_ready held low 5 cycles during a continuous stream → at most 2 samples buffered, in_ready low, outputs stable, order preserved, zero loss after release.
- Same-cycle cfg_we and sample on ch0 (old hi = 127, new hi = 10, data 64) → output 64; the next sample of 64 → 10 (ovf_hi).
- With SAT_FILTER_STATS_EN and CNT_W = 2: 5 clamps on ch3 → stat_cnt = 3 (saturated); stat_clr together with a clamp → 0.
